mem_dump_reader: RTL and testbench
==================================

Name: mem_dump_reader

Overview:
- Reads back data memory after program termination and streams every word out, in ascending address order, over a valid/ready interface to the testbench or host.
- The CPU pipeline writes data memory through the MEM stage. This block is the read side of that memory, sitting beside the MEM-stage memory on its second (read-only) port.
- Dumping is triggered by the WB-stage terminate flag. The block replaces ad-hoc simulation dumps with a synthesizable, back-pressurable readout.

Parameters:
- DEPTH, 512, number of data-memory words to dump (addresses 0..DEPTH-1).
- ADDR_W, 9, memory word-address width; must satisfy 2**ADDR_W >= DEPTH.
- Data width is `WORD (32) from constants.v; it is not a parameter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- terminate  in  1  terminate flag from the WB stage (may be a level or a pulse).
- mem_rd_en  out  1  read strobe to the memory read port.
- mem_rd_addr  out  ADDR_W  word address of the read.
- mem_rd_data  in  `WORD  read data, valid exactly 1 cycle after mem_rd_en (synchronous RAM).
- dump_valid  out  1  dump word available.
- dump_ready  in  1  consumer accepts the word.
- dump_data  out  `WORD  memory word.
- dump_addr  out  ADDR_W  address of dump_data.
- dump_last  out  1  marks the word at address DEPTH-1.
- busy  out  1  dump in progress.
- done  out  1  sticky; all DEPTH words have been accepted.

Behaviour:
- Reset (rst low, asynchronous): FSM=IDLE; issue address, in-flight flag and FIFO cleared.
  - All outputs 0: mem_rd_en, mem_rd_addr, dump_valid, dump_data, dump_addr, dump_last, busy, done.
- FSM states: IDLE -> READ -> DRAIN -> DONE.
  - IDLE: terminate sampled high at edge k -> READ. busy=1 from k.
  - READ: issues reads at addresses 0..DEPTH-1, one per cycle at most. After the read of DEPTH-1 is issued -> DRAIN.
  - DRAIN: no reads issued. The last handshake (dump_valid & dump_ready with dump_last=1) -> DONE.
  - DONE: busy=0, done=1. Terminal until reset; terminate is ignored.
- terminate is ignored outside IDLE. A dump runs exactly once per reset.
- Read pipeline: a 1-cycle in-flight register, followed by a 2-entry output FIFO holding {data, addr, last}.
  - A read is issued in a cycle only if (fifo_count + inflight - pop) < 2, where pop = dump_valid & dump_ready in that cycle.
  - This credit rule guarantees no FIFO overflow and no lost RAM data.
- Latency:
  - terminate sampled at edge k -> mem_rd_en=1, addr 0 during cycle k..k+1.
  - Data is captured at edge k+2, so dump_valid=1 after edge k+2.
- Throughput: with dump_ready held high, one word per cycle. DEPTH words occupy DEPTH consecutive valid cycles.
- Handshake rules:
  - Once dump_valid=1, dump_valid, dump_data, dump_addr and dump_last stay stable until dump_ready=1.
  - dump_valid never depends combinationally on dump_ready.
- Order: strictly ascending, no gaps, no repeats. dump_addr equals the RAM address the data was read from.
- dump_last=1 only with the word at DEPTH-1. DEPTH=1 gives a single word with dump_last=1.
- Address counter does not wrap; it stops after DEPTH-1 is issued.
- Back-pressure (dump_ready low for any duration): at most 2 words are buffered, then reads stall with mem_rd_en=0. No data loss.
- A simultaneous push and pop with the FIFO full is legal; the count is unchanged.
- Reset asserted mid-dump: immediate abort, outputs return to reset values. A fresh terminate is needed to restart from address 0.
- The memory is assumed quiescent during the dump (the pipeline has terminated). This block does not arbitrate against MEM-stage writes.

Decomposition:
- constants.v: `WORD, plus the new state encodings `DUMP_IDLE, `DUMP_READ, `DUMP_DRAIN, `DUMP_DONE (2-bit).
- One sub-module: dump_fifo2, a 2-entry synchronous FIFO (push, pop, full, empty, count, async active-low reset). It is reusable for other back-pressured stream outputs.

Test Plan (DEPTH=8, RAM preloaded with mem[i] = 32'hA000_0000 + i):
- Reset, terminate pulsed 1 cycle, dump_ready=1 -> mem_rd_en first asserted the cycle after terminate is sampled; dump_valid 2 cycles after terminate.
  - Then 8 consecutive handshakes with data A0000000..A0000007, addr 0..7, dump_last only on addr 7.
  - done=1 and busy=0 the cycle after the last handshake.
- dump_ready toggles 1,0,0,1,... (fixed pattern) -> identical 8-word sequence.
  - Outputs stable while stalled; FIFO count never exceeds 2; mem_rd_en=0 whenever credit is exhausted.
- dump_ready=0 for 20 cycles after start -> exactly 2 reads issued, dump_valid=1 with addr 0 held. Releasing dump_ready drains all 8 words in order.
- terminate held high for 50 cycles, then re-pulsed after done -> exactly one 8-word dump; no second dump; done stays 1.
- rst driven low asynchronously (mid-cycle) after the handshake of addr 3 -> all outputs 0 immediately.
  - After release with no terminate: stays IDLE. With terminate: a full dump restarts from addr 0.
- DEPTH=1 build -> single word A0000000, addr 0, dump_last=1, then done.

Source files
------------

// File: rtl/mem_dump_reader_pkg.sv
// Shared word width, dump FSM encodings and the read-credit rule for the
// post-termination data-memory dump.
package mem_dump_reader_pkg;

    localparam int WORD = 32;

    typedef enum logic [1:0] {
        DUMP_IDLE  = 2'd0,
        DUMP_READ  = 2'd1,
        DUMP_DRAIN = 2'd2,
        DUMP_DONE  = 2'd3
    } dump_state_t;

    // A new read may be issued only while (count + inflight - pop) < 2,
    // so every word already requested always has a FIFO slot waiting for it.
    function automatic logic read_credit(input logic       full,
                                         input logic [1:0] count,
                                         input logic       inflight,
                                         input logic       pop);
        if (full)
            return pop && !inflight;
        return ({1'b0, count} + {2'b00, inflight}) < (3'd2 + {2'b00, pop});
    endfunction

endpackage

// File: rtl/dump_fifo2.sv
// Two-entry synchronous FIFO for back-pressured stream outputs; a push into a
// full FIFO is accepted only together with a pop.
module dump_fifo2 #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] head_data,
    output logic         full,
    output logic         empty,
    output logic [1:0]   count
);

    logic [W-1:0] entry [2];
    logic         wr_ptr;
    logic         rd_ptr;
    logic         do_push;
    logic         do_pop;

    assign do_pop  = pop && (count != 2'd0);
    assign do_push = push && ((count != 2'd2) || do_pop);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            entry[0] <= '0;
            entry[1] <= '0;
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            count    <= 2'd0;
        end else begin
            if (do_push) begin
                entry[wr_ptr] <= push_data;
                wr_ptr        <= ~wr_ptr;
            end
            if (do_pop)
                rd_ptr <= ~rd_ptr;
            case ({do_push, do_pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    assign head_data = entry[rd_ptr];
    assign full      = (count == 2'd2);
    assign empty     = (count == 2'd0);

endmodule

// File: rtl/mem_dump_reader.sv
// Streams data memory 0..DEPTH-1 out over valid/ready once the WB stage
// signals termination; runs exactly once per reset.
module mem_dump_reader
    import mem_dump_reader_pkg::*;
#(
    parameter int DEPTH  = 512,
    parameter int ADDR_W = 9
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              terminate,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_rd_addr,
    input  logic [WORD-1:0]   mem_rd_data,
    output logic              dump_valid,
    input  logic              dump_ready,
    output logic [WORD-1:0]   dump_data,
    output logic [ADDR_W-1:0] dump_addr,
    output logic              dump_last,
    output logic              busy,
    output logic              done
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam int                ENTRY_W   = WORD + ADDR_W + 1;

    dump_state_t       state;
    logic [ADDR_W-1:0] issue_addr;
    logic              inflight;
    logic [ADDR_W-1:0] inflight_addr;
    logic              inflight_last;
    logic              pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [1:0]        fifo_count;
    logic [ENTRY_W-1:0] head;

    assign pop         = dump_valid && dump_ready;
    assign mem_rd_en   = (state == DUMP_READ) &&
                         read_credit(fifo_full, fifo_count, inflight, pop);
    assign mem_rd_addr = issue_addr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= DUMP_IDLE;
            issue_addr <= '0;
        end else begin
            case (state)
                DUMP_IDLE: begin
                    if (terminate)
                        state <= DUMP_READ;
                end
                DUMP_READ: begin
                    // The counter parks on the last address instead of wrapping.
                    if (mem_rd_en) begin
                        if (issue_addr == LAST_ADDR)
                            state <= DUMP_DRAIN;
                        else
                            issue_addr <= issue_addr + 1'b1;
                    end
                end
                DUMP_DRAIN: begin
                    if (pop && dump_last)
                        state <= DUMP_DONE;
                end
                default: state <= DUMP_DONE;
            endcase
        end
    end

    // RAM data lags the strobe by one cycle; carry its address alongside.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            inflight      <= 1'b0;
            inflight_addr <= '0;
            inflight_last <= 1'b0;
        end else begin
            inflight <= mem_rd_en;
            if (mem_rd_en) begin
                inflight_addr <= issue_addr;
                inflight_last <= (issue_addr == LAST_ADDR);
            end
        end
    end

    dump_fifo2 #(
        .W (ENTRY_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (inflight),
        .push_data ({mem_rd_data, inflight_addr, inflight_last}),
        .pop       (pop),
        .head_data (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign {dump_data, dump_addr, dump_last} = head;
    assign dump_valid = !fifo_empty;
    assign busy       = (state == DUMP_READ) || (state == DUMP_DRAIN);
    assign done       = (state == DUMP_DONE);

endmodule

// File: tb/tb_mem_dump_reader.sv
// Directed bench for mem_dump_reader: DEPTH=8 main instance plus a DEPTH=1 build,
// with a queue of expected dump words checked as handshakes occur.
module tb_mem_dump_reader;

    typedef struct {
        logic [31:0] data;
        logic [2:0]  addr;
        logic        last;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        terminate;
    logic        mem_rd_en;
    logic [2:0]  mem_rd_addr;
    logic [31:0] mem_rd_data;
    logic        dump_valid;
    logic        dump_ready;
    logic [31:0] dump_data;
    logic [2:0]  dump_addr;
    logic        dump_last;
    logic        busy;
    logic        done;

    logic        terminate2;
    logic        mem_rd_en2;
    logic [0:0]  mem_rd_addr2;
    logic [31:0] mem_rd_data2;
    logic        dump_valid2;
    logic        dump_ready2;
    logic [31:0] dump_data2;
    logic [0:0]  dump_addr2;
    logic        dump_last2;
    logic        busy2;
    logic        done2;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int rd_count = 0;
    int n_popped = 0;
    int first_pop_cyc = -1;
    int last_pop_cyc  = -1;

    exp_t        sb[$];
    logic        prev_stall = 1'b0;
    logic [31:0] held_data;
    logic [2:0]  held_addr;
    logic        held_last;

    mem_dump_reader #(.DEPTH(8), .ADDR_W(3)) dut (
        .clk         (clk),
        .rst         (rst),
        .terminate   (terminate),
        .mem_rd_en   (mem_rd_en),
        .mem_rd_addr (mem_rd_addr),
        .mem_rd_data (mem_rd_data),
        .dump_valid  (dump_valid),
        .dump_ready  (dump_ready),
        .dump_data   (dump_data),
        .dump_addr   (dump_addr),
        .dump_last   (dump_last),
        .busy        (busy),
        .done        (done)
    );

    mem_dump_reader #(.DEPTH(1), .ADDR_W(1)) dut1 (
        .clk         (clk),
        .rst         (rst),
        .terminate   (terminate2),
        .mem_rd_en   (mem_rd_en2),
        .mem_rd_addr (mem_rd_addr2),
        .mem_rd_data (mem_rd_data2),
        .dump_valid  (dump_valid2),
        .dump_ready  (dump_ready2),
        .dump_data   (dump_data2),
        .dump_addr   (dump_addr2),
        .dump_last   (dump_last2),
        .busy        (busy2),
        .done        (done2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous RAM models preloaded with mem[i] = A000_0000 + i.
    always @(posedge clk) begin
        if (mem_rd_en)
            mem_rd_data <= 32'hA000_0000 + {29'd0, mem_rd_addr};
        if (mem_rd_en2)
            mem_rd_data2 <= 32'hA000_0000 + {31'd0, mem_rd_addr2};
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic expect_dump(input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            e.data = 32'hA000_0000 + i;
            e.addr = 3'(i);
            e.last = (i == n - 1);
            sb.push_back(e);
        end
    endtask

    task automatic clear_stats();
        rd_count      = 0;
        n_popped      = 0;
        prev_stall    = 1'b0;
        first_pop_cyc = -1;
        last_pop_cyc  = -1;
    endtask

    // Sample on the falling edge, then advance through the rising edge.
    task automatic step();
        exp_t e;
        @(negedge clk);
        if (mem_rd_en)
            rd_count++;
        if (dump_valid && prev_stall) begin
            check("stall_data", dump_data, held_data);
            check("stall_addr", dump_addr, held_addr);
            check("stall_last", dump_last, held_last);
        end
        if (dump_valid && dump_ready) begin
            check("word_expected", sb.size() != 0, 1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("dump_data", dump_data, e.data);
                check("dump_addr", dump_addr, e.addr);
                check("dump_last", dump_last, e.last);
            end
            if (first_pop_cyc < 0)
                first_pop_cyc = cyc;
            if (dump_last)
                last_pop_cyc = cyc;
            n_popped++;
            prev_stall = 1'b0;
        end else if (dump_valid) begin
            prev_stall = 1'b1;
            held_data  = dump_data;
            held_addr  = dump_addr;
            held_last  = dump_last;
        end else begin
            prev_stall = 1'b0;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_rd_en"},  mem_rd_en, 0);
        check({tag, "_addr"},   mem_rd_addr, 0);
        check({tag, "_valid"},  dump_valid, 0);
        check({tag, "_data"},   dump_data, 0);
        check({tag, "_daddr"},  dump_addr, 0);
        check({tag, "_last"},   dump_last, 0);
        check({tag, "_busy"},   busy, 0);
        check({tag, "_done"},   done, 0);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        sb.delete();
        repeat (2) step();
        rst = 1'b1;
        clear_stats();
    endtask

    task automatic run_to_done(input int budget);
        for (int i = 0; i < budget && done !== 1'b1; i++)
            step();
    endtask

    initial begin
        bit [3:0] pat;
        rst         = 1'b0;
        terminate   = 1'b0;
        dump_ready  = 1'b1;
        terminate2  = 1'b0;
        dump_ready2 = 1'b1;
        #2;
        check_outputs_zero("reset");
        repeat (2) step();
        rst = 1'b1;
        repeat (3) step();
        check("idle_busy", busy, 0);
        check("idle_rd_en", mem_rd_en, 0);

        // Test 1: single-cycle terminate, consumer always ready.
        clear_stats();
        expect_dump(8);
        terminate = 1'b1;
        step();
        terminate = 1'b0;
        check("t1_rd_en_k", mem_rd_en, 1);
        check("t1_rd_addr_k", mem_rd_addr, 0);
        check("t1_busy_k", busy, 1);
        check("t1_valid_k", dump_valid, 0);
        step();
        check("t1_valid_k1", dump_valid, 0);
        step();
        check("t1_valid_k2", dump_valid, 1);
        check("t1_addr_k2", dump_addr, 0);
        run_to_done(40);
        check("t1_done", done, 1);
        check("t1_busy_end", busy, 0);
        check("t1_done_latency", cyc - last_pop_cyc, 1);
        check("t1_consecutive", last_pop_cyc - first_pop_cyc, 7);
        check("t1_words", n_popped, 8);
        check("t1_reads", rd_count, 8);
        check("t1_sb_empty", sb.size(), 0);

        // Test 2: fixed ready pattern 1,0,0,1.
        do_reset();
        pat = 4'b1001;
        expect_dump(8);
        terminate = 1'b1;
        step();
        terminate = 1'b0;
        for (int i = 0; i < 80 && done !== 1'b1; i++) begin
            dump_ready = pat[i % 4];
            step();
        end
        dump_ready = 1'b1;
        check("t2_done", done, 1);
        check("t2_words", n_popped, 8);
        check("t2_reads", rd_count, 8);
        check("t2_sb_empty", sb.size(), 0);

        // Test 3: consumer stalled for 20 cycles after start.
        do_reset();
        dump_ready = 1'b0;
        expect_dump(8);
        terminate = 1'b1;
        step();
        terminate = 1'b0;
        repeat (20) step();
        check("t3_reads_stalled", rd_count, 2);
        check("t3_valid_held", dump_valid, 1);
        check("t3_addr_held", dump_addr, 0);
        check("t3_data_held", dump_data, 32'hA000_0000);
        check("t3_rd_en_stalled", mem_rd_en, 0);
        dump_ready = 1'b1;
        run_to_done(40);
        check("t3_done", done, 1);
        check("t3_reads", rd_count, 8);
        check("t3_sb_empty", sb.size(), 0);

        // Test 4: terminate held high, then re-pulsed after done.
        do_reset();
        expect_dump(8);
        terminate = 1'b1;
        repeat (50) step();
        terminate = 1'b0;
        check("t4_done", done, 1);
        check("t4_reads", rd_count, 8);
        step();
        terminate = 1'b1;
        step();
        terminate = 1'b0;
        repeat (10) step();
        check("t4_reads_after", rd_count, 8);
        check("t4_words_after", n_popped, 8);
        check("t4_done_sticky", done, 1);
        check("t4_busy_after", busy, 0);

        // Test 5: asynchronous reset after the handshake of address 3.
        do_reset();
        expect_dump(8);
        terminate = 1'b1;
        step();
        terminate = 1'b0;
        for (int i = 0; i < 40 && n_popped < 4; i++)
            step();
        check("t5_popped_before_abort", n_popped, 4);
        #2;
        rst = 1'b0;
        #1;
        check_outputs_zero("t5_abort");
        sb.delete();
        step();
        rst = 1'b1;
        clear_stats();
        repeat (10) step();
        check("t5_idle_busy", busy, 0);
        check("t5_idle_reads", rd_count, 0);
        check("t5_idle_valid", dump_valid, 0);
        expect_dump(8);
        terminate = 1'b1;
        step();
        terminate = 1'b0;
        check("t5_restart_addr", mem_rd_addr, 0);
        run_to_done(40);
        check("t5_done", done, 1);
        check("t5_words", n_popped, 8);
        check("t5_sb_empty", sb.size(), 0);

        // Test 6: DEPTH=1 build.
        terminate2 = 1'b1;
        step();
        terminate2 = 1'b0;
        check("d1_busy", busy2, 1);
        for (int i = 0; i < 10 && dump_valid2 !== 1'b1; i++)
            step();
        check("d1_valid", dump_valid2, 1);
        check("d1_data", dump_data2, 32'hA000_0000);
        check("d1_addr", dump_addr2, 0);
        check("d1_last", dump_last2, 1);
        step();
        check("d1_done", done2, 1);
        check("d1_busy_end", busy2, 0);
        check("d1_valid_end", dump_valid2, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
